// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared transaction-layer constants and types. The FIFO and router blocks
// import these so that channel count, payload width and the destination field
// stay consistent across the layer.
//   TL_DATA_W  : default payload width
//   TL_N_CH    : default number of input/output channels
//   TL_DEST_W  : destination / source index width for TL_N_CH channels
//   tl_dest_t  : destination field type
// -----------------------------------------------------------------------------
package tl_pkg;

    localparam int TL_DATA_W = 8;
    localparam int TL_N_CH   = 4;
    localparam int TL_DEST_W = $clog2(TL_N_CH);

    typedef logic [TL_DEST_W-1:0] tl_dest_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin priority search. Returns the first set bit of 'eligible' found
// when scanning ptr, ptr+1, ... with wrap-around modulo N.
//   eligible : per-channel request vector
//   ptr      : channel with highest priority this cycle (0..N-1)
//   grant    : one-hot grant, all zero when nothing is eligible
//   valid    : at least one channel eligible
//   idx      : index of the granted channel
// -----------------------------------------------------------------------------
module rr_pick
    import tl_pkg::*;
#(
    parameter int N     = TL_N_CH,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_X = (IDX_W+1)'(N);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    always_comb begin
        // Shifting the doubled vector right by ptr puts channel ptr at bit 0
        // and brings the wrapped channels in above it.
        rot   = N'({eligible, eligible} >> ptr);
        valid = 1'b0;
        off   = '0;
        // Scan downwards so the lowest set bit is the one left standing.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = IDX_W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_X) begin
            sum = sum - N_X;
        end
        idx   = sum[IDX_W-1:0];
        grant = valid ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/arbitro_rr.sv
// -----------------------------------------------------------------------------
// arbitro_rr
// Round-robin arbiter/router between transaction-layer input and output FIFOs.
// Each cycle at most one non-empty input whose destination can accept data is
// popped; its word is pushed one cycle later to the output named by its
// destination field. Words with an out-of-range destination are dropped and
// flagged on dest_err.
//   clk, reset_L : clock, asynchronous active-low reset
//   arb_en       : 0 suppresses grants; pointer and output lanes hold
//   in_data      : head word per input, lane i at [i*DATA_W +: DATA_W]
//   in_dest      : destination of each head word
//   in_empty     : input FIFO empty flags
//   out_full     : output FIFO almost-full flags (one slot still free)
//   in_pop       : combinational one-hot pop to the inputs
//   out_push     : registered one-hot push to the outputs
//   out_data     : registered payload per output lane
//   out_src      : registered source index per output lane
//   dest_err     : registered pulse when a word with a bad destination is dropped
// -----------------------------------------------------------------------------
module arbitro_rr
    import tl_pkg::*;
#(
    parameter int N_CH   = TL_N_CH,
    parameter int DATA_W = TL_DATA_W,
    parameter int DEST_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     arb_en,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH*DEST_W-1:0]   in_dest,
    input  logic [N_CH-1:0]          in_empty,
    input  logic [N_CH-1:0]          out_full,
    output logic [N_CH-1:0]          in_pop,
    output logic [N_CH-1:0]          out_push,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH*DEST_W-1:0]   out_src,
    output logic                     dest_err
);

    localparam logic [DEST_W:0]   N_CH_X  = (DEST_W+1)'(N_CH);
    localparam logic [DEST_W-1:0] LAST_CH = DEST_W'(N_CH - 1);

    logic [DEST_W-1:0] ptr;
    logic [DEST_W-1:0] dest_of [N_CH];
    logic [N_CH-1:0]   dest_ok;
    logic [N_CH-1:0]   tgt_full;
    logic [N_CH-1:0]   elig;
    logic [N_CH-1:0]   grant;
    logic              pick_valid;
    logic [DEST_W-1:0] pick_idx;
    logic [DATA_W-1:0] g_data;
    logic [DEST_W-1:0] g_dest;
    logic              g_dest_ok;

    // Eligibility. A bad destination only needs a non-empty input so the word
    // can be drained; a good one also needs room at its output.
    always_comb begin
        dest_ok  = '0;
        tgt_full = '0;
        elig     = '0;
        for (int i = 0; i < N_CH; i++) begin
            dest_of[i] = in_dest[i*DEST_W +: DEST_W];
            dest_ok[i] = ({1'b0, dest_of[i]} < N_CH_X);
            for (int d = 0; d < N_CH; d++) begin
                if (dest_of[i] == DEST_W'(d)) begin
                    tgt_full[i] = out_full[d];
                end
            end
            elig[i] = arb_en & ~in_empty[i] & (~dest_ok[i] | ~tgt_full[i]);
        end
    end

    rr_pick #(
        .N     (N_CH),
        .IDX_W (DEST_W)
    ) u_pick (
        .eligible (elig),
        .ptr      (ptr),
        .grant    (grant),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    assign in_pop = reset_L ? grant : '0;

    always_comb begin
        g_data    = '0;
        g_dest    = '0;
        g_dest_ok = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                g_data    = in_data[i*DATA_W +: DATA_W];
                g_dest    = dest_of[i];
                g_dest_ok = dest_ok[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr      <= '0;
            out_push <= '0;
            out_data <= '0;
            out_src  <= '0;
            dest_err <= 1'b0;
        end else begin
            out_push <= '0;
            dest_err <= 1'b0;
            if (pick_valid) begin
                // Explicit wrap: N_CH need not be a power of two.
                ptr <= (pick_idx == LAST_CH) ? '0 : pick_idx + DEST_W'(1);
                if (g_dest_ok) begin
                    for (int d = 0; d < N_CH; d++) begin
                        if (g_dest == DEST_W'(d)) begin
                            out_push[d]                   <= 1'b1;
                            out_data[d*DATA_W +: DATA_W] <= g_data;
                            out_src[d*DEST_W +: DEST_W]  <= pick_idx;
                        end
                    end
                end else begin
                    dest_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_arbitro_rr.sv
module tb_arbitro_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_L;

    logic        en4, derr4;
    logic [31:0] din4, od4;
    logic [7:0]  dst4, os4;
    logic [3:0]  emp4, full4, pop4, push4;

    logic        en3, derr3;
    logic [23:0] din3, od3;
    logic [5:0]  dst3, os3;
    logic [2:0]  emp3, full3, pop3, push3;

    int vectors = 0;
    int miscompares = 0;

    // stimulus, index 0 = 4-channel instance, 1 = 3-channel instance
    bit          t_en    [2];
    bit          t_empty [2][4];
    bit          t_full  [2][4];
    int          t_dest  [2][4];
    logic [7:0]  t_din   [2][4];

    // reference model
    int          m_ptr  [2];
    bit          m_push [2][4];
    logic [7:0]  m_data [2][4];
    int          m_src  [2][4];
    bit          m_err  [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            din4[i*8 +: 8] = t_din[0][i];
            dst4[i*2 +: 2] = t_dest[0][i][1:0];
            emp4[i]        = t_empty[0][i];
            full4[i]       = t_full[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            din3[i*8 +: 8] = t_din[1][i];
            dst3[i*2 +: 2] = t_dest[1][i][1:0];
            emp3[i]        = t_empty[1][i];
            full3[i]       = t_full[1][i];
        end
        en4 = t_en[0];
        en3 = t_en[1];
    end

    arbitro_rr #(.N_CH(4), .DATA_W(8), .DEST_W(2)) u_dut4 (
        .clk(clk), .reset_L(reset_L), .arb_en(en4),
        .in_data(din4), .in_dest(dst4), .in_empty(emp4), .out_full(full4),
        .in_pop(pop4), .out_push(push4), .out_data(od4), .out_src(os4),
        .dest_err(derr4)
    );

    arbitro_rr #(.N_CH(3), .DATA_W(8), .DEST_W(2)) u_dut3 (
        .clk(clk), .reset_L(reset_L), .arb_en(en3),
        .in_data(din3), .in_dest(dst3), .in_empty(emp3), .out_full(full3),
        .in_pop(pop3), .out_push(push3), .out_data(od3), .out_src(os3),
        .dest_err(derr3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int nch(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // first eligible input scanning from the pointer, -1 if none
    function automatic int pick(input int k);
        int n, c;
        n = nch(k);
        if (reset_L !== 1'b1 || !t_en[k]) return -1;
        for (int j = 0; j < n; j++) begin
            c = (m_ptr[k] + j) % n;
            if (!t_empty[k][c]) begin
                if (t_dest[k][c] >= n) return c;
                if (!t_full[k][t_dest[k][c]]) return c;
            end
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int g);
        logic [31:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_err[k] = 1'b0;
            for (int d = 0; d < 4; d++) begin
                m_push[k][d] = 1'b0;
                m_data[k][d] = 8'h00;
                m_src[k][d]  = 0;
            end
        end
    endtask

    task automatic m_update(input int k, input int g);
        int n, d;
        n = nch(k);
        m_err[k] = 1'b0;
        for (int j = 0; j < 4; j++) m_push[k][j] = 1'b0;
        if (g >= 0) begin
            m_ptr[k] = (g + 1) % n;
            d = t_dest[k][g];
            if (d < n) begin
                m_push[k][d] = 1'b1;
                m_data[k][d] = t_din[k][g];
                m_src[k][d]  = g;
            end else begin
                m_err[k] = 1'b1;
            end
        end
    endtask

    // one clock: check pops before the edge, registered outputs after it
    task automatic cycle();
        int g [2];
        logic [31:0] ep, ed, es;
        @(negedge clk);
        for (int k = 0; k < 2; k++) g[k] = pick(k);
        chk("pop4", 32'(pop4), oh(g[0]));
        chk("pop3", 32'(pop3), oh(g[1]));
        @(posedge clk);
        #1;
        if (reset_L === 1'b1) begin
            for (int k = 0; k < 2; k++) m_update(k, g[k]);
        end
        for (int k = 0; k < 2; k++) begin
            ep = '0; ed = '0; es = '0;
            for (int d = 0; d < nch(k); d++) begin
                ep[d]        = m_push[k][d];
                ed[d*8 +: 8] = m_data[k][d];
                es[d*2 +: 2] = m_src[k][d][1:0];
            end
            if (k == 0) begin
                chk("push4", 32'(push4), ep);
                chk("data4", od4, ed);
                chk("src4", 32'(os4), es);
                chk("err4", 32'(derr4), 32'(m_err[0]));
            end else begin
                chk("push3", 32'(push3), ep);
                chk("data3", 32'(od3), ed);
                chk("src3", 32'(os3), es);
                chk("err3", 32'(derr3), 32'(m_err[1]));
            end
        end
        vectors++;
    endtask

    task automatic load_rotation();
        for (int i = 0; i < 4; i++) begin
            t_empty[0][i] = 1'b0;
            t_full[0][i]  = 1'b0;
            t_dest[0][i]  = 3 - i;
            t_din[0][i]   = 8'hA0 + 8'(i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset_L = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t_en[k] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                t_empty[k][i] = 1'b1;
                t_full[k][i]  = 1'b0;
                t_dest[k][i]  = 0;
                t_din[k][i]   = 8'h00;
            end
        end
        m_reset();

        // reset state
        #12;
        chk("rst_push4", 32'(push4), 32'h0);
        chk("rst_data4", od4, 32'h0);
        chk("rst_src4", 32'(os4), 32'h0);
        chk("rst_err4", 32'(derr4), 32'h0);
        chk("rst_push3", 32'(push3), 32'h0);
        chk("rst_err3", 32'(derr3), 32'h0);
        load_rotation();
        #1;
        chk("rst_pop4", 32'(pop4), 32'h0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        // rotation 0,1,2,3,0...
        #1;
        chk("rot_first_pop", 32'(pop4), 32'h1);
        cycle();
        chk("rot_first_push", 32'(push4), 32'h8);
        chk("rot_first_data", 32'(od4[31:24]), 32'hA0);
        chk("rot_first_src", 32'(os4[7:6]), 32'h0);
        for (int c = 1; c < 9; c++) begin
            chk("rot_pop", 32'(pop4), 32'h1 << (c % 4));
            cycle();
        end

        // reset mid-stream: registered push dropped at once
        reset_L = 1'b0;
        #1;
        chk("midrst_push4", 32'(push4), 32'h0);
        chk("midrst_pop4", 32'(pop4), 32'h0);
        m_reset();
        cycle();
        reset_L = 1'b1;

        // skip empty: only 1 and 3 loaded, both to dest 0
        for (int i = 0; i < 4; i++) begin
            t_empty[0][i] = (i % 2 == 0);
            t_dest[0][i]  = 0;
        end
        t_din[0][1] = 8'hB1;
        t_din[0][3] = 8'hB3;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("skip_pop", 32'(pop4), (c % 2 == 0) ? 32'h2 : 32'h8);
            cycle();
            chk("skip_push", 32'(push4), 32'h1);
            chk("skip_data", 32'(od4[7:0]), (c % 2 == 0) ? 32'hB1 : 32'hB3);
        end

        // back-pressure on dest 2
        t_empty[0][0] = 1'b0; t_empty[0][1] = 1'b0;
        t_empty[0][2] = 1'b1; t_empty[0][3] = 1'b1;
        t_dest[0][0] = 2; t_dest[0][1] = 1;
        t_full[0][2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_pop", 32'(pop4), 32'h2);
            cycle();
        end
        t_full[0][2] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            #1;
            if (pop4[0]) seen = 1'b1;
            cycle();
        end
        chk("bp_release", 32'(seen), 32'h1);

        // disable: pointer left at 2, then 5 idle cycles
        reset_L = 1'b0;
        #1;
        m_reset();
        cycle();
        reset_L = 1'b1;
        load_rotation();
        cycle();
        cycle();
        t_en[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("dis_pop", 32'(pop4), 32'h0);
            cycle();
            chk("dis_push", 32'(push4), 32'h0);
        end
        t_en[0] = 1'b1;
        #1;
        chk("reen_pop", 32'(pop4), 32'h4);
        cycle();

        // invalid destination on the 3-channel instance
        t_empty[1][2] = 1'b0;
        t_dest[1][2]  = 3;
        t_din[1][2]   = 8'h5C;
        #1;
        chk("inv_pop", 32'(pop3), 32'h4);
        cycle();
        chk("inv_err", 32'(derr3), 32'h1);
        chk("inv_push", 32'(push3), 32'h0);
        t_empty[1][2] = 1'b1;
        cycle();
        chk("inv_err_clear", 32'(derr3), 32'h0);

        // randomized traffic on both instances
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                t_en[k] = ($urandom_range(0, 9) != 0);
                for (int i = 0; i < 4; i++) begin
                    t_empty[k][i] = ($urandom_range(0, 2) == 0);
                    t_full[k][i]  = ($urandom_range(0, 3) == 0);
                    t_dest[k][i]  = $urandom_range(0, 3);
                    t_din[k][i]   = 8'($urandom);
                end
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
